// File: rtl/tri_pkg.sv
// Shared definitions for the triangle rasterizer and its frame buffer:
// coordinate/counter widths and the frame buffer state encoding.
package tri_pkg;
  localparam int COORD_W = 3;
  localparam int CNT_W   = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READOUT = 2'd2
  } state_e;
endpackage

// File: rtl/tri_frame_buffer_if.sv
// Pixel-in / row-out bundle of the frame buffer. The master drives the pixel stream
// and the sink ready; the slave (frame buffer) drives rows, status and debug state.
interface tri_frame_buffer_if #(
  parameter int COORD_W = tri_pkg::COORD_W,
  parameter int CNT_W   = tri_pkg::CNT_W
) ();
  localparam int SIDE = 1 << COORD_W;

  logic               busy;
  logic               po;
  logic [COORD_W-1:0] xo;
  logic [COORD_W-1:0] yo;
  logic               rd_ready;
  // Row handshake: a row transfers on any cycle with row_valid & rd_ready both high;
  // while row_valid is high and rd_ready low, row_idx/row_data hold steady.
  logic               row_valid;
  logic [COORD_W-1:0] row_idx;
  logic [SIDE-1:0]    row_data;
  logic               frame_done;
  logic [CNT_W-1:0]   pix_count;
  logic [CNT_W-1:0]   dup_count;
  logic               overrun;
  tri_pkg::state_e    dbg_state;

  modport master (
    output busy, po, xo, yo, rd_ready,
    input  row_valid, row_idx, row_data, frame_done, pix_count, dup_count, overrun, dbg_state
  );

  modport slave (
    input  busy, po, xo, yo, rd_ready,
    output row_valid, row_idx, row_data, frame_done, pix_count, dup_count, overrun, dbg_state
  );
endinterface

// File: rtl/tri_row_mux.sv
// Selects one row of the square one-bit bitmap; bit i of the row is column x=i.
module tri_row_mux #(
  parameter int COORD_W = 3
) (
  input  logic [(1<<COORD_W)-1:0][(1<<COORD_W)-1:0] bitmap_i,
  input  logic [COORD_W-1:0]                        sel_i,
  output logic [(1<<COORD_W)-1:0]                   row_o
);
  assign row_o = bitmap_i[sel_i];
endmodule

// File: rtl/tri_frame_buffer.sv
// Captures the rasterizer pixel stream into a bitmap while busy is high, then replays
// it row by row over a valid/ready port once busy falls.
module tri_frame_buffer #(
  parameter int COORD_W = tri_pkg::COORD_W,
  parameter int CNT_W   = tri_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  tri_frame_buffer_if.slave  bus
);
  import tri_pkg::*;

  localparam int                 SIDE     = 1 << COORD_W;
  localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(SIDE - 1);

  state_e                     state_q, state_d;
  logic                       busy_q;
  logic [SIDE-1:0][SIDE-1:0]  bitmap_q, bitmap_d;
  logic                       row_valid_q, row_valid_d;
  logic [COORD_W-1:0]         row_idx_q, row_idx_d;
  logic [SIDE-1:0]            row_data_q, row_data_d;
  logic                       frame_done_q, frame_done_d;
  logic [CNT_W-1:0]           pix_count_q, pix_count_d;
  logic [CNT_W-1:0]           dup_count_q, dup_count_d;
  logic                       overrun_q, overrun_d;
  logic [COORD_W-1:0]         mux_sel;
  logic [SIDE-1:0]            mux_row;
  logic                       rise, fall;

  assign rise = bus.busy & ~busy_q;
  assign fall = ~bus.busy & busy_q;

  // Outside READOUT the mux serves row 0 for the first presentation; inside it looks one row ahead.
  assign mux_sel = (state_q == READOUT) ? row_idx_q + COORD_W'(1) : '0;

  tri_row_mux #(.COORD_W(COORD_W)) u_row_mux (
    .bitmap_i (bitmap_q),
    .sel_i    (mux_sel),
    .row_o    (mux_row)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bitmap_d     = bitmap_q;
    row_valid_d  = row_valid_q;
    row_idx_d    = row_idx_q;
    row_data_d   = row_data_q;
    frame_done_d = 1'b0;
    pix_count_d  = pix_count_q;
    dup_count_d  = dup_count_q;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          bitmap_d    = '0;
          pix_count_d = '0;
          dup_count_d = '0;
          state_d     = CAPTURE;
          if (bus.po) begin
            bitmap_d[bus.yo][bus.xo] = 1'b1;
            pix_count_d              = CNT_W'(1);
          end
        end
      end
      CAPTURE: begin
        if (bus.po && bus.busy) begin
          if (bitmap_q[bus.yo][bus.xo]) begin
            if (dup_count_q != '1) dup_count_d = dup_count_q + CNT_W'(1);
          end else begin
            bitmap_d[bus.yo][bus.xo] = 1'b1;
            pix_count_d              = pix_count_q + CNT_W'(1);
          end
        end
        if (fall) begin
          state_d     = READOUT;
          row_idx_d   = '0;
          row_valid_d = 1'b1;
          row_data_d  = mux_row;
        end
      end
      READOUT: begin
        // A frame starting now cannot be captured; it is flagged and dropped.
        if (rise) overrun_d = 1'b1;
        if (bus.rd_ready) begin
          if (row_idx_q == LAST_ROW) begin
            row_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            row_idx_d  = row_idx_q + COORD_W'(1);
            row_data_d = mux_row;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_q       <= 1'b0;
      bitmap_q     <= '0;
      row_valid_q  <= 1'b0;
      row_idx_q    <= '0;
      row_data_q   <= '0;
      frame_done_q <= 1'b0;
      pix_count_q  <= '0;
      dup_count_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      busy_q       <= bus.busy;
      bitmap_q     <= bitmap_d;
      row_valid_q  <= row_valid_d;
      row_idx_q    <= row_idx_d;
      row_data_q   <= row_data_d;
      frame_done_q <= frame_done_d;
      pix_count_q  <= pix_count_d;
      dup_count_q  <= dup_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.row_valid  = row_valid_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.row_data   = row_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pix_count  = pix_count_q;
  assign bus.dup_count  = dup_count_q;
  assign bus.overrun    = overrun_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_tri_frame_buffer.sv
// Randomized bench for tri_frame_buffer: frames are modelled as pixel sets, rows are
// rebuilt from the set and compared on every readout cycle.
module tb_tri_frame_buffer;
  import tri_pkg::*;

  localparam int SIDE    = 1 << COORD_W;
  localparam int DUP_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tri_frame_buffer_if ifc ();
  tri_frame_buffer dut (.clk(clk), .reset(reset), .bus(ifc));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the set of lit pixels, distinct count, duplicate count, sticky overrun.
  bit               mb [SIDE][SIDE];
  int               m_pix;
  int               m_dup;
  bit               m_ovr;
  logic [6:0]       pix_q [$];   // {po, y, x} per busy cycle
  logic [SIDE-1:0]  exp_q [$];
  logic [SIDE-1:0]  last_rows [SIDE];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int y = 0; y < SIDE; y++)
      for (int x = 0; x < SIDE; x++) mb[y][x] = 1'b0;
    m_pix = 0;
    m_dup = 0;
  endtask

  task automatic model_hit(input int x, input int y);
    if (mb[y][x]) begin
      if (m_dup < DUP_MAX) m_dup++;
    end else begin
      mb[y][x] = 1'b1;
      m_pix++;
    end
  endtask

  function automatic logic [SIDE-1:0] model_row(input int r);
    logic [SIDE-1:0] row;
    for (int x = 0; x < SIDE; x++) row[x] = mb[r][x];
    return row;
  endfunction

  task automatic push_pix(input int po, input int x, input int y);
    pix_q.push_back({1'(po), 3'(y), 3'(x)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},      32'(ifc.dbg_state),  32'(IDLE));
    check({tag, "_row_valid"},  32'(ifc.row_valid),  32'(0));
    check({tag, "_row_idx"},    32'(ifc.row_idx),    32'(0));
    check({tag, "_row_data"},   32'(ifc.row_data),   32'(0));
    check({tag, "_frame_done"}, 32'(ifc.frame_done), 32'(0));
    check({tag, "_pix_count"},  32'(ifc.pix_count),  32'(0));
    check({tag, "_dup_count"},  32'(ifc.dup_count),  32'(0));
    check({tag, "_overrun"},    32'(ifc.overrun),    32'(0));
  endtask

  // Plays pix_q as one frame, then drains the readout. ovr_row >= 0 raises busy while
  // that row is presented; rdy_mode 0 = always ready, 1 = 1,0,0 pattern, 2 = random.
  task automatic run_frame(input int ovr_row, input int rdy_mode);
    logic [6:0] e;
    int         exp_idx;
    int         cyc;
    int         ovr_left;
    bit         raised;
    bit         rdy;
    ifc.busy     = 1'b0;
    ifc.po       = 1'($urandom);
    ifc.xo       = 3'($urandom);
    ifc.yo       = 3'($urandom);
    ifc.rd_ready = 1'($urandom);
    step();
    check("idle_state", 32'(ifc.dbg_state), 32'(IDLE));
    check("idle_row_valid", 32'(ifc.row_valid), 32'(0));
    model_clear();
    while (pix_q.size() > 0) begin
      e            = pix_q.pop_front();
      ifc.busy     = 1'b1;
      ifc.po       = e[6];
      ifc.yo       = e[5:3];
      ifc.xo       = e[2:0];
      ifc.rd_ready = 1'($urandom);
      if (e[6]) model_hit(int'(e[2:0]), int'(e[5:3]));
      step();
    end
    ifc.busy = 1'b0;
    ifc.po   = 1'($urandom);
    ifc.xo   = 3'($urandom);
    ifc.yo   = 3'($urandom);
    step();
    for (int r = 0; r < SIDE; r++) exp_q.push_back(model_row(r));
    exp_idx  = 0;
    cyc      = 0;
    ovr_left = 0;
    raised   = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      check("row_valid", 32'(ifc.row_valid), 32'(1));
      check("row_idx", 32'(ifc.row_idx), 32'(exp_idx));
      check("row_data", 32'(ifc.row_data), 32'(exp_q[0]));
      check("frame_done_early", 32'(ifc.frame_done), 32'(0));
      if (exp_idx == ovr_row && !raised) begin
        raised   = 1'b1;
        ovr_left = 3;
        m_ovr    = 1'b1;
      end
      if (ovr_left > 0) begin
        ifc.busy = 1'b1;
        ifc.po   = 1'b1;
        ifc.xo   = 3'($urandom);
        ifc.yo   = 3'($urandom);
        ovr_left--;
      end else begin
        ifc.busy = 1'b0;
        ifc.po   = 1'($urandom);
      end
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom);
      endcase
      ifc.rd_ready = rdy;
      if (rdy) last_rows[exp_idx] = ifc.row_data;
      step();
      cyc++;
      if (rdy) begin
        void'(exp_q.pop_front());
        exp_idx++;
      end
    end
    if (exp_q.size() > 0) begin
      check("readout_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
    check("frame_done", 32'(ifc.frame_done), 32'(1));
    check("row_valid_after", 32'(ifc.row_valid), 32'(0));
    check("pix_count", 32'(ifc.pix_count), 32'(m_pix));
    check("dup_count", 32'(ifc.dup_count), 32'(m_dup));
    check("overrun", 32'(ifc.overrun), 32'(m_ovr));
    ifc.busy     = 1'b0;
    ifc.po       = 1'b0;
    ifc.rd_ready = 1'($urandom);
    step();
    check("frame_done_pulse", 32'(ifc.frame_done), 32'(0));
    check("back_to_idle", 32'(ifc.dbg_state), 32'(IDLE));
    check("pix_count_hold", 32'(ifc.pix_count), 32'(m_pix));
  endtask

  task automatic push_base_frame();
    push_pix(1, 0, 0); push_pix(1, 1, 0); push_pix(1, 2, 0);
    push_pix(1, 0, 1); push_pix(1, 1, 1); push_pix(1, 0, 2);
  endtask

  task automatic check_base_rows(input string tag);
    logic [SIDE-1:0] want [SIDE];
    for (int r = 0; r < SIDE; r++) want[r] = '0;
    want[0] = 8'h07;
    want[1] = 8'h03;
    want[2] = 8'h01;
    for (int r = 0; r < SIDE; r++) check($sformatf("%s_row%0d", tag, r), 32'(last_rows[r]), 32'(want[r]));
  endtask

  initial begin
    int n;
    int ovr;
    reset        = 1'b0;
    ifc.busy     = 1'b0;
    ifc.po       = 1'b0;
    ifc.xo       = '0;
    ifc.yo       = '0;
    ifc.rd_ready = 1'b0;
    m_ovr        = 1'b0;
    model_clear();
    step();
    step();
    check_reset_outputs("reset");
    reset = 1'b1;
    step();

    // Six-pixel triangle, sink always ready.
    push_base_frame();
    run_frame(-1, 0);
    check_base_rows("tri");
    check("tri_pix_const", 32'(ifc.pix_count), 32'(6));

    // Same triangle with (1,1) repeated.
    push_base_frame();
    push_pix(1, 1, 1);
    run_frame(-1, 0);
    check_base_rows("dup");
    check("dup_const", 32'(ifc.dup_count), 32'(1));

    // Stalling sink.
    push_base_frame();
    push_pix(1, 7, 5);
    push_pix(0, 3, 3);
    run_frame(-1, 1);

    // Busy rises during row 3 of readout.
    push_base_frame();
    run_frame(3, 0);
    check_base_rows("ovr");
    check("ovr_const", 32'(ifc.overrun), 32'(1));
    push_pix(1, 4, 4);
    run_frame(-1, 2);
    check("ovr_sticky", 32'(ifc.overrun), 32'(1));

    // Reset in the middle of a capture, then a single corner pixel.
    ifc.busy = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      ifc.busy = 1'b1;
      ifc.po   = 1'b1;
      ifc.xo   = 3'($urandom);
      ifc.yo   = 3'($urandom);
      step();
    end
    reset    = 1'b0;
    ifc.busy = 1'b0;
    ifc.po   = 1'b0;
    step();
    check_reset_outputs("midrst");
    m_ovr = 1'b0;
    reset = 1'b1;
    push_pix(1, 7, 7);
    run_frame(-1, 2);
    check("corner_row7", 32'(last_rows[7]), 32'(8'h80));
    for (int r = 0; r < 7; r++) check($sformatf("corner_row%0d", r), 32'(last_rows[r]), 32'(0));
    check("corner_pix", 32'(ifc.pix_count), 32'(1));

    // Duplicate counter saturation.
    for (int i = 0; i < 140; i++) push_pix(1, 5, 2);
    run_frame(-1, 0);
    check("dup_saturated", 32'(ifc.dup_count), 32'(DUP_MAX));

    // Random frames.
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++)
        push_pix(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7));
      ovr = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1;
      run_frame(ovr, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
